snake_head_ctrl: RTL

- Consumes the one-cycle `move` tick from the game-speed timer and advances the snake head one cell per tick on a GRID_W x GRID_H board.
- Latches keyboard direction requests, blocks 180-degree reversals, detects wall/body collision and food pickup, and tracks snake length.
- Outputs a registered step strobe with the new head coordinate for the downstream body-buffer and display stages.

---
 rtl/snake_pkg.sv | 26 ++
 rtl/snake_next_pos.sv | 54 +++++
 rtl/snake_head_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared encodings and board defaults for the snake game pipeline
// (speed timer, head control, body buffer, display).
package snake_pkg;

  localparam int unsigned GRID_W_DEFAULT = 40;
  localparam int unsigned GRID_H_DEFAULT = 30;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  // Opposite heading: the encoding places opposites two apart.
  function automatic dir_e reverse_dir(input dir_e d);
    return dir_e'(d ^ 2'd2);
  endfunction

endpackage

// File: rtl/snake_next_pos.sv
// Combinational next-head calculator: one cell step in the given direction,
// with either a wall (out_of_bounds) or wrap-around at the board edges.
module snake_next_pos
  import snake_pkg::*;
#(
  parameter int unsigned GRID_W = GRID_W_DEFAULT,
  parameter int unsigned GRID_H = GRID_H_DEFAULT,
  parameter int unsigned XW     = 6,
  parameter int unsigned YW     = 5,
  parameter bit          WRAP   = 1'b0
) (
  input  logic [XW-1:0] head_x,
  input  logic [YW-1:0] head_y,
  input  dir_e          dir,
  output logic [XW-1:0] next_x,
  output logic [YW-1:0] next_y,
  output logic          out_of_bounds
);

  localparam logic [XW:0] XMAX = (XW+1)'(GRID_W - 1);
  localparam logic [YW:0] YMAX = (YW+1)'(GRID_H - 1);

  logic [XW:0] x_ext;
  logic [YW:0] y_ext;
  logic        x_out;
  logic        y_out;

  // One extra bit so that 0-1 underflows to all-ones and compares above the max.
  always_comb begin
    x_ext = {1'b0, head_x};
    y_ext = {1'b0, head_y};
    unique case (dir)
      DIR_UP:    y_ext = y_ext - 1'b1;
      DIR_RIGHT: x_ext = x_ext + 1'b1;
      DIR_DOWN:  y_ext = y_ext + 1'b1;
      DIR_LEFT:  x_ext = x_ext - 1'b1;
      default:   ;
    endcase
    x_out = (x_ext > XMAX);
    y_out = (y_ext > YMAX);

    next_x        = x_ext[XW-1:0];
    next_y        = y_ext[YW-1:0];
    out_of_bounds = 1'b0;
    if (WRAP) begin
      // Direction decides the wrap target; the carry bit is ambiguous when 2^XW == GRID_W.
      if (x_out) next_x = (dir == DIR_LEFT) ? XW'(GRID_W - 1) : '0;
      if (y_out) next_y = (dir == DIR_UP)   ? YW'(GRID_H - 1) : '0;
    end else begin
      out_of_bounds = x_out | y_out;
    end
  end

endmodule

// File: rtl/snake_head_ctrl.sv
// Snake head controller: moves the head one cell per move tick, filters
// reversals, detects walls/body hits/food. SNAKE_WRAP_EN enables edge wrap.
module snake_head_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned GRID_W   = GRID_W_DEFAULT,
  parameter int unsigned GRID_H   = GRID_H_DEFAULT,
  parameter int unsigned XW       = 6,
  parameter int unsigned YW       = 5,
  parameter int unsigned START_X  = 20,
  parameter int unsigned START_Y  = 15,
  parameter int unsigned LEN_W    = 8,
  parameter int unsigned LEN_INIT = 3
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic             move,
  input  logic             dir_valid,
  input  logic [1:0]       dir,
  input  logic             body_hit,
  input  logic [XW-1:0]    food_x,
  input  logic [YW-1:0]    food_y,
  output logic [XW-1:0]    head_x,
  output logic [YW-1:0]    head_y,
  output logic [1:0]       cur_dir,
  output logic             step,
  output logic             ate,
  output logic [LEN_W-1:0] length,
  output logic             game_over,
  output logic [1:0]       state
);

`ifdef SNAKE_WRAP_EN
  localparam bit WrapEn = 1'b1;
`else
  localparam bit WrapEn = 1'b0;
`endif

  localparam logic [XW-1:0]    HeadX0 = XW'(START_X);
  localparam logic [YW-1:0]    HeadY0 = YW'(START_Y);
  localparam logic [LEN_W-1:0] Len0   = LEN_W'(LEN_INIT);

  state_e            state_q, state_d;
  logic [XW-1:0]     head_x_q, head_x_d;
  logic [YW-1:0]     head_y_q, head_y_d;
  dir_e              cur_dir_q, cur_dir_d;
  dir_e              pend_dir_q, pend_dir_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              step_q, step_d;
  logic              ate_q, ate_d;
  logic              over_q, over_d;

  logic [XW-1:0]     nxt_x;
  logic [YW-1:0]     nxt_y;
  logic              nxt_oob;
  dir_e              req_dir;

  assign req_dir = dir_e'(dir);

  snake_next_pos #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H),
    .XW     (XW),
    .YW     (YW),
    .WRAP   (WrapEn)
  ) u_next_pos (
    .head_x        (head_x_q),
    .head_y        (head_y_q),
    .dir           (pend_dir_q),
    .next_x        (nxt_x),
    .next_y        (nxt_y),
    .out_of_bounds (nxt_oob)
  );

  always_comb begin
    state_d    = state_q;
    head_x_d   = head_x_q;
    head_y_d   = head_y_q;
    cur_dir_d  = cur_dir_q;
    pend_dir_d = pend_dir_q;
    len_d      = len_q;
    step_d     = 1'b0;
    ate_d      = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_d    = ST_RUN;
          head_x_d   = HeadX0;
          head_y_d   = HeadY0;
          cur_dir_d  = DIR_RIGHT;
          pend_dir_d = DIR_RIGHT;
          len_d      = Len0;
        end
      end
      ST_RUN: begin
        if (body_hit) begin
          state_d = ST_OVER;
        end else begin
          if (move) begin
            cur_dir_d = pend_dir_q;
            if (nxt_oob) begin
              state_d = ST_OVER;
            end else begin
              head_x_d = nxt_x;
              head_y_d = nxt_y;
              step_d   = 1'b1;
              if (nxt_x == food_x && nxt_y == food_y) begin
                ate_d = 1'b1;
                if (len_q != {LEN_W{1'b1}}) len_d = len_q + 1'b1;
              end
            end
          end
          // Reversal check uses the pre-tick heading even when move fires this cycle.
          if (dir_valid && req_dir != reverse_dir(cur_dir_q)) pend_dir_d = req_dir;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    over_d = (state_d == ST_OVER);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= ST_IDLE;
      head_x_q   <= HeadX0;
      head_y_q   <= HeadY0;
      cur_dir_q  <= DIR_RIGHT;
      pend_dir_q <= DIR_RIGHT;
      len_q      <= Len0;
      step_q     <= 1'b0;
      ate_q      <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_x_q   <= head_x_d;
      head_y_q   <= head_y_d;
      cur_dir_q  <= cur_dir_d;
      pend_dir_q <= pend_dir_d;
      len_q      <= len_d;
      step_q     <= step_d;
      ate_q      <= ate_d;
      over_q     <= over_d;
    end
  end

  assign head_x    = head_x_q;
  assign head_y    = head_y_q;
  assign cur_dir   = cur_dir_q;
  assign step      = step_q;
  assign ate       = ate_q;
  assign length    = len_q;
  assign game_over = over_q;
  assign state     = state_q;

endmodule
